mfp_ahb_lite_master: RTL and testbench

Single-outstanding AHB-Lite initiator. Converts a simple valid/ready request interface into AHB-Lite single transfers (NONSEQ, HBURST=SINGLE), honouring wait states and the two-cycle ERROR response. Returns read data and status on a one-cycle response strobe. Drives the existing AHB-Lite slaves (EIC, GPIO, RAM) from test engines, debug bridges or small DMA front-ends.

---
 rtl/mfp_ahb_lite_master_pkg.sv | 46 ++++
 rtl/mfp_ahb_lite_master_if.sv | 41 ++++
 rtl/mfp_ahb_lite_master_timeout.sv | 33 +++
 rtl/mfp_ahb_lite_master.sv | 149 ++++++++++++++
 tb/tb_mfp_ahb_lite_master.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mfp_ahb_lite_master_pkg.sv
// Shared AHB-Lite codes, FSM state encoding and request payload for mfp_ahb_lite_master.
package mfp_ahb_lite_master_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR2 = 2'd3
   } state_e;

   typedef struct packed {
      logic              write;
      logic [2:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Size 3 is reserved; halfwords and words must be naturally aligned.
   function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return addr_lo[0];
         2'd2:    return |addr_lo;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mfp_ahb_lite_master_if.sv
// AHB-Lite bus plus request/response port of mfp_ahb_lite_master, with initiator and peer views.
interface mfp_ahb_lite_master_if;
   import mfp_ahb_lite_master_pkg::*;

   logic [ADDR_W-1:0] HADDR;
   logic [2:0]        HBURST;
   logic              HMASTLOCK;
   logic [3:0]        HPROT;
   logic [2:0]        HSIZE;
   logic [1:0]        HTRANS;
   logic [DATA_W-1:0] HWDATA;
   logic              HWRITE;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY;
   logic              HRESP;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_error;

   modport master (
      output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
      input  HRDATA, HREADY, HRESP,
      input  req_valid, req_write, req_addr, req_size, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
      output HRDATA, HREADY, HRESP,
      output req_valid, req_write, req_addr, req_size, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

endinterface

// File: rtl/mfp_ahb_lite_master_timeout.sv
// Wait-state watchdog: counts consecutive HREADY-low edges while a transfer is open and
// flags expiry on the edge where the count reaches TIMEOUT_CYCLES-1.
module mfp_ahb_lite_master_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic active_i,
   input  logic hready_i,
   output logic expired_c
);
   localparam int unsigned CntW = 16;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign expired_c = active_i & ~hready_i & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (active_i && !hready_i && !expired_c) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mfp_ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready request in, SINGLE NONSEQ transfer out.
// Define MFP_AHB_LITE_MASTER_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES.
module mfp_ahb_lite_master
   import mfp_ahb_lite_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                   HCLK,
   input logic                   HRESET,
   mfp_ahb_lite_master_if.master bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mfp_ahb_lite_master: TIMEOUT_CYCLES must lie in 2..65535");
   end

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_error_q, resp_error_d;
   logic              finish_c;
   logic              timeout_c;

`ifdef MFP_AHB_LITE_MASTER_TIMEOUT_EN
   mfp_ahb_lite_master_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (HCLK),
      .rst       (HRESET),
      .active_i  (state_q != ST_IDLE),
      .hready_i  (bus.HREADY),
      .expired_c (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      htrans_d     = htrans_q;
      hwdata_d     = hwdata_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_error_d = 1'b0;
      finish_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               if (req_illegal(bus.req_size, bus.req_addr[1:0])) begin
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end else begin
                  state_d     = ST_ADDR;
                  htrans_d    = HTRANS_NONSEQ;
                  req_ready_d = 1'b0;
                  req_d.write = bus.req_write;
                  req_d.size  = {1'b0, bus.req_size};
                  req_d.addr  = bus.req_addr;
                  req_d.wdata = bus.req_wdata;
               end
            end
         end
         ST_ADDR: begin
            if (timeout_c) begin
               finish_c     = 1'b1;
               resp_error_d = 1'b1;
            end else if (bus.HREADY) begin
               state_d  = ST_DATA;
               htrans_d = HTRANS_IDLE;
               if (req_q.write) begin
                  hwdata_d = req_q.wdata;
               end
            end
         end
         ST_DATA: begin
            if (timeout_c) begin
               finish_c     = 1'b1;
               resp_error_d = 1'b1;
            end else if (bus.HREADY) begin
               finish_c     = 1'b1;
               resp_error_d = (bus.HRESP == HRESP_ERROR);
               if (!req_q.write && bus.HRESP != HRESP_ERROR) begin
                  resp_rdata_d = bus.HRDATA;
               end
            end else if (bus.HRESP == HRESP_ERROR) begin
               state_d = ST_ERR2;
            end
         end
         ST_ERR2: begin
            finish_c     = timeout_c | bus.HREADY;
            resp_error_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Completion, error and abort all return to IDLE with a one-cycle response.
      if (finish_c) begin
         state_d      = ST_IDLE;
         htrans_d     = HTRANS_IDLE;
         req_ready_d  = 1'b1;
         resp_valid_d = 1'b1;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q      <= ST_IDLE;
         req_q        <= '0;
         htrans_q     <= HTRANS_IDLE;
         hwdata_q     <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         htrans_q     <= htrans_d;
         hwdata_q     <= hwdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   assign bus.HADDR      = req_q.addr;
   assign bus.HSIZE      = req_q.size;
   assign bus.HWRITE     = req_q.write;
   assign bus.HTRANS     = htrans_q;
   assign bus.HWDATA     = hwdata_q;
   assign bus.HBURST     = HBURST_SINGLE;
   assign bus.HMASTLOCK  = 1'b0;
   assign bus.HPROT      = HPROT_DATA_PRIV;
   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Self-checking bench for mfp_ahb_lite_master: directed table, randomized transfers against a
// transaction-level model, back-to-back/reset sequence and (with the macro) the timeout abort.
module tb_mfp_ahb_lite_master;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   mfp_ahb_lite_master_if bus();

   mfp_ahb_lite_master #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   typedef struct {
      string       name;
      logic        write;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      int          ap_w;
      int          dp_w;
      logic        err;
      logic [31:0] rdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_nns;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural slave state
   int          sl_ap_left, sl_dp_left, sl_dp_w, sl_phase;
   bit          sl_dp, sl_err, sl_err1;
   logic [31:0] sl_rdata;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic write, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata, input int ap_w,
                               input int dp_w, input logic err, input logic [31:0] rdata,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input int exp_lat, input int exp_nns);
      vec_t v;
      v.name = name; v.write = write; v.addr = addr; v.size = size; v.wdata = wdata;
      v.ap_w = ap_w; v.dp_w = dp_w; v.err = err; v.rdata = rdata;
      v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_nns = exp_nns;
      return v;
   endfunction

   // Transaction-level expectation: legality by alignment arithmetic, latency by phase counting.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int unsigned nbytes;
      bit          illegal;
      r       = v;
      nbytes  = 32'd1 << v.size;
      illegal = (v.size == 2'd3) || ((v.addr % nbytes) != 0);
      if (illegal) begin
         r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_lat = 1; r.exp_nns = 0;
      end else begin
         r.exp_err   = v.err;
         r.exp_rdata = (v.write || v.err) ? 32'h0 : v.rdata;
         r.exp_lat   = 1 + (v.ap_w + 1) + (v.dp_w + 1) + (v.err ? 1 : 0);
         r.exp_nns   = v.ap_w + 1;
      end
      return r;
   endfunction

   task automatic slave_clear();
      sl_ap_left = 0; sl_dp_left = 0; sl_dp_w = 0; sl_phase = 0;
      sl_dp = 0; sl_err = 0; sl_err1 = 0; sl_rdata = '0;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
   endtask

   // Advance one clock; then the slave decides HREADY/HRESP/HRDATA for the coming edge.
   task automatic step();
      @(posedge HCLK);
      #1;
      bus.HRDATA = $urandom();
      if (sl_dp) begin
         sl_phase = 2;
         if (sl_dp_left > 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b0; sl_dp_left--;
         end else if (sl_err && !sl_err1) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b1; sl_err1 = 1;
         end else begin
            bus.HREADY = 1'b1; bus.HRESP = sl_err;
            if (!sl_err) bus.HRDATA = sl_rdata;
            sl_dp = 0;
         end
      end else if (bus.HTRANS == 2'b10) begin
         sl_phase = 1;
         bus.HRESP = 1'b0;
         if (sl_ap_left > 0) begin
            bus.HREADY = 1'b0; sl_ap_left--;
         end else begin
            bus.HREADY = 1'b1; sl_dp = 1; sl_dp_left = sl_dp_w; sl_err1 = 0;
         end
      end else begin
         sl_phase = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
   endtask

   task automatic run_txn(input vec_t v);
      bit hs;
      int lat, nns, bad_a, bad_r, bad_d;
      sl_ap_left = v.ap_w; sl_dp_w = v.dp_w; sl_err = v.err; sl_rdata = v.rdata;
      bus.req_valid = 1'b1; bus.req_write = v.write; bus.req_addr = v.addr;
      bus.req_size = v.size; bus.req_wdata = v.wdata;
      hs = 0;
      for (int i = 0; i < 50; i++) begin
         hs = bus.req_ready;
         step();
         if (hs) break;
      end
      bus.req_valid = 1'b0;
      chk({v.name, "_handshake"}, 64'(hs), 64'd1);
      lat = 1; nns = 0; bad_a = 0; bad_r = 0; bad_d = 0;
      while (!bus.resp_valid && lat < 300) begin
         if (bus.HTRANS == 2'b10) begin
            nns++;
            if (bus.HADDR !== v.addr || bus.HSIZE !== {1'b0, v.size} || bus.HWRITE !== v.write)
               bad_a++;
         end
         if (bus.req_ready !== 1'b0) bad_r++;
         if (sl_phase == 2) begin
            if (bus.HTRANS !== 2'b00) bad_d++;
            if (v.write && bus.HWDATA !== v.wdata) bad_d++;
         end
         step();
         lat++;
      end
      chk({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
      chk({v.name, "_resp_error"}, 64'(bus.resp_error), 64'(v.exp_err));
      chk({v.name, "_resp_rdata"}, 64'(bus.resp_rdata), 64'(v.exp_rdata));
      chk({v.name, "_nonseq_cycles"}, 64'(nns), 64'(v.exp_nns));
      chk({v.name, "_addr_phase_bad"}, 64'(bad_a), 64'd0);
      chk({v.name, "_busy_ready_bad"}, 64'(bad_r), 64'd0);
      chk({v.name, "_data_phase_bad"}, 64'(bad_d), 64'd0);
      chk({v.name, "_resp_cycle_ready_htrans"}, 64'({bus.req_ready, bus.HTRANS}), 64'h4);
      step();
      chk({v.name, "_pulse_width"}, 64'(bus.resp_valid), 64'd0);
   endtask

   initial begin
      vec_t tbl[9];
      vec_t v;
      int   k, cnt;

      HRESET = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_size = '0; bus.req_wdata = '0;
      slave_clear();
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      chk("reset_htrans", 64'(bus.HTRANS), 64'd0);
      chk("reset_haddr", 64'(bus.HADDR), 64'd0);
      chk("reset_hsize_hwrite", 64'({bus.HSIZE, bus.HWRITE}), 64'd0);
      chk("reset_hwdata", 64'(bus.HWDATA), 64'd0);
      chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset_resp", 64'({bus.resp_valid, bus.resp_error, bus.resp_rdata}), 64'd0);
      chk("const_hburst_hlock_hprot", 64'({bus.HBURST, bus.HMASTLOCK, bus.HPROT}), 64'h03);

      //            name                 wr addr          sz wdata         ap dp er rdata         e  exp_rdata     lat nns
      tbl[0] = mk("rd_word_zero_wait",  0, 32'h1F800004, 2, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 1);
      tbl[1] = mk("wr_word_3_waits",    1, 32'h00000010, 2, 32'h12345678, 0, 3, 0, 32'h0,        0, 32'h0,        6, 1);
      tbl[2] = mk("rd_slave_error",     0, 32'h00000020, 2, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 1, 32'h0,        4, 1);
      tbl[3] = mk("half_misaligned",    0, 32'h00000003, 1, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 0);
      tbl[4] = mk("size_3_illegal",     1, 32'h00000000, 3, 32'h11111111, 0, 0, 0, 32'h0,        1, 32'h0,        1, 0);
      tbl[5] = mk("word_misaligned",    0, 32'h00000006, 2, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        1, 0);
      tbl[6] = mk("rd_byte_addr_waits", 0, 32'h00000003, 0, 32'h0,        2, 1, 0, 32'hA5A50000, 0, 32'hA5A50000, 6, 3);
      tbl[7] = mk("wr_half_err_waits",  1, 32'h00000102, 1, 32'hBEEF0000, 1, 2, 1, 32'h0,        1, 32'h0,        7, 2);
      tbl[8] = mk("rd_half_waits",      0, 32'h00001002, 1, 32'h0,        0, 2, 0, 32'h1234ABCD, 0, 32'h1234ABCD, 5, 1);
      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      for (int i = 0; i < 40; i++) begin
         v.name  = $sformatf("rnd%0d", i);
         v.write = 1'($urandom_range(0, 1));
         v.size  = 2'($urandom_range(0, 3));
         v.addr  = $urandom();
         if ($urandom_range(0, 3) != 0) v.addr = v.addr & 32'hFFFF_FFFC;
         v.wdata = $urandom();
         v.ap_w  = $urandom_range(0, 2);
         v.dp_w  = $urandom_range(0, 3);
         v.err   = 1'($urandom_range(0, 4) == 0);
         v.rdata = $urandom();
         v = model(v);
         repeat ($urandom_range(0, 2)) step();
         run_txn(v);
      end

      // Back-to-back reads, then reset inside the second address phase.
      sl_ap_left = 0; sl_dp_w = 0; sl_err = 0; sl_rdata = 32'hCAFE0001;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h40;
      k = 0;
      while (!bus.req_ready && k < 20) begin step(); k++; end
      step();
      bus.req_addr = 32'h44;
      k = 0;
      while (!bus.resp_valid && k < 20) begin step(); k++; end
      chk("b2b_first_resp", 64'({bus.resp_valid, bus.resp_error, bus.resp_rdata}), 64'h2_CAFE0001);
      chk("b2b_ready_with_resp_no_overlap", 64'({bus.req_ready, bus.HTRANS}), 64'h4);
      step();
      bus.req_valid = 1'b0;
      chk("b2b_second_addr_phase", 64'({bus.HTRANS, bus.HADDR}), {30'd0, 2'b10, 32'h44});
      HRESET = 1'b1;
      #2;
      chk("midrst_htrans_haddr", 64'({bus.HTRANS, bus.HADDR}), 64'd0);
      chk("midrst_ready_resp", 64'({bus.req_ready, bus.resp_valid, bus.resp_error}), 64'h4);
      chk("midrst_hwdata", 64'(bus.HWDATA), 64'd0);
      @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      slave_clear();
      cnt = 0;
      repeat (6) begin step(); if (bus.resp_valid) cnt++; end
      chk("midrst_no_response", 64'(cnt), 64'd0);

`ifdef MFP_AHB_LITE_MASTER_TIMEOUT_EN
      // Slave stalls 20 data-phase cycles; the 8-cycle watchdog fires first.
      run_txn(mk("timeout_abort", 0, 32'h80, 2, 32'h0, 0, 20, 0, 32'h5555AAAA, 1, 32'h0, 10, 1));
      cnt = 0;
      repeat (30) begin step(); if (bus.resp_valid) cnt++; end
      chk("timeout_late_ready_ignored", 64'(cnt), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
